// File: rtl/present_inv_sbox_layer_d2.sv
// 3-share masked PRESENT inverse S-box layer, one nibble per cycle, core latency 3.
// INV_SBOX_OUT_CLEAR_EN: clear the result shares on an accepted start.
`timescale 1ns/1ps
module present_inv_sbox_layer_d2 #(
   parameter int NIBBLES = 16,
   parameter int RW      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] in1,
   input  logic [4*NIBBLES-1:0] in2,
   input  logic [4*NIBBLES-1:0] in3,
   input  logic [RW-1:0]        r,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] out1,
   output logic [4*NIBBLES-1:0] out2,
   output logic [4*NIBBLES-1:0] out3
);
   localparam int W = 4 * NIBBLES;
   localparam logic [4:0] COL_FIRST = 5'd3;
   localparam logic [4:0] CNT_DONE  = 5'(NIBBLES + 2);
   localparam logic [4:0] CNT_LAST  = 5'(NIBBLES + 3);
   localparam int PA [6] = '{0, 0, 1, 0, 1, 2};
   localparam int PB [6] = '{1, 2, 2, 3, 3, 3};

   typedef logic [2:0][3:0] nib3_t;

   function automatic logic [2:0] col(input nib3_t s, input int b);
      return {s[2][b], s[1][b], s[0][b]};
   endfunction

   // Non-complete product: share i never sees input share i.
   function automatic logic [2:0] ti_and(input logic [2:0] a,
                                         input logic [2:0] b);
      logic [2:0] z;
      z[0] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
      z[1] = (a[2] & b[2]) ^ (a[0] & b[2]) ^ (a[2] & b[0]);
      z[2] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
      return z;
   endfunction

   logic [2:0][W-1:0] in_s, sh_q, sh_d, out_q, out_d;
   nib3_t             reg0_q, reg0_d, reg1x_q, reg2l_q, reg2l_d, l_s, y;
   logic [2:0][5:0]   reg1p_q, reg1p_d;
   logic [2:0][2:0]   reg2c_q, reg2c_d;
   logic [2:0]        zf, p01, p02, c0v, c1v, c2v;
   logic [4:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              accept, collect;

   assign in_s = {in3, in2, in1};

   // Stage F: all six degree-2 monomials, refreshed with r.
   always_comb begin
      reg1p_d = '0;
      zf      = '0;
      for (int j = 0; j < 6; j++) begin
         zf = ti_and(col(reg0_q, PA[j]), col(reg0_q, PB[j]));
         reg1p_d[0][j] = zf[0] ^ r[j];
         reg1p_d[1][j] = zf[1] ^ r[j+2];
         reg1p_d[2][j] = zf[2] ^ r[j] ^ r[j+2];
      end
   end

   // Middle affine layer: linear part of Sinv over x and the monomials.
   always_comb begin
      l_s = '0;
      for (int i = 0; i < 3; i++) begin
         l_s[i][0] = reg1x_q[i][0] ^ reg1x_q[i][2] ^ reg1p_q[i][4];
         l_s[i][1] = reg1x_q[i][0] ^ reg1x_q[i][1] ^ reg1x_q[i][3]
                   ^ reg1p_q[i][1] ^ reg1p_q[i][4] ^ reg1p_q[i][5];
         l_s[i][2] = reg1x_q[i][3] ^ reg1p_q[i][0] ^ reg1p_q[i][1]
                   ^ reg1p_q[i][2] ^ reg1p_q[i][3] ^ reg1p_q[i][4];
         l_s[i][3] = reg1x_q[i][0] ^ reg1x_q[i][1] ^ reg1x_q[i][2]
                   ^ reg1x_q[i][3] ^ reg1p_q[i][0];
      end
   end

   // Stage G: cubic terms x0x1x2, x0x1x3, x0x2x3.
   assign p01 = {reg1p_q[2][0], reg1p_q[1][0], reg1p_q[0][0]};
   assign p02 = {reg1p_q[2][1], reg1p_q[1][1], reg1p_q[0][1]};
   assign c0v = ti_and(p01, col(reg1x_q, 2));
   assign c1v = ti_and(p01, col(reg1x_q, 3));
   assign c2v = ti_and(p02, col(reg1x_q, 3));

   // Linear shares rotate so each slot still misses one input share.
   always_comb begin
      reg2c_d = '0;
      for (int i = 0; i < 3; i++)
         reg2c_d[i] = {c2v[i], c1v[i], c0v[i]};
      reg2l_d = {l_s[0], l_s[2], l_s[1]};
   end

   // Output affine layer; the Sinv constant 5 goes on share 1.
   always_comb begin
      y = '0;
      for (int i = 0; i < 3; i++)
         y[i] = reg2l_q[i] ^ {reg2c_q[i][0] ^ reg2c_q[i][2],
                              ^reg2c_q[i], ^reg2c_q[i], 1'b0};
      y[0] = y[0] ^ 4'h5;
   end

   assign accept  = start & (~busy_q | done_q);
   assign collect = busy_q & (cnt_q >= COL_FIRST) & (cnt_q <= CNT_DONE);

   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      reg0_d = reg0_q;
      out_d  = out_q;
      if (collect)
         for (int i = 0; i < 3; i++)
            out_d[i] = {y[i], out_q[i][W-1:4]};
      if (accept) begin
         busy_d = 1'b1;
         cnt_d  = 5'd1;
         for (int i = 0; i < 3; i++) begin
            sh_d[i]   = in_s[i] >> 4;
            reg0_d[i] = in_s[i][3:0];
         end
`ifdef INV_SBOX_OUT_CLEAR_EN
         out_d = '0;
`endif
      end else if (busy_q) begin
         cnt_d = cnt_q + 5'd1;
         for (int i = 0; i < 3; i++) begin
            sh_d[i]   = sh_q[i] >> 4;
            reg0_d[i] = sh_q[i][3:0];
         end
         if (cnt_q == CNT_DONE) done_d = 1'b1;
         if (cnt_q == CNT_LAST) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q    <= '0;
         reg0_q  <= '0;
         reg1x_q <= '0;
         reg1p_q <= '0;
         reg2l_q <= '0;
         reg2c_q <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         reg0_q  <= reg0_d;
         reg1x_q <= reg0_q;
         reg1p_q <= reg1p_d;
         reg2l_q <= reg2l_d;
         reg2c_q <= reg2c_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out1 = out_q[0];
   assign out2 = out_q[1];
   assign out3 = out_q[2];
endmodule

// File: doc/present_inv_sbox_layer_d2.md
Name: present_inv_sbox_layer_d2

Overview:
- Second-order masked (3-share) PRESENT inverse S-box layer for the decryption datapath; counterpart of the forward masked S-box used in encryption.
- Processes one 64-bit state serially: one nibble per cycle through a single pipelined masked inverse S-box. Each cycle costs 8 bits of fresh randomness in the first nonlinear stage and none in the second.
- Sits between key addition and the inverse pLayer in the masked PRESENT decryption round.

Parameters:
- NIBBLES, 16, number of 4-bit nibbles per state; the state width is 4*NIBBLES.
- RW, 8, fresh random bits consumed per nibble by the first quadratic stage.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to process the state presented on in1..in3; ignored while busy=1.
- in1  input  64  share 1 of the input state.
- in2  input  64  share 2 of the input state.
- in3  input  64  share 3 of the input state.
- r  input  RW  fresh randomness; must be uniform and new in every cycle while busy=1.
- busy  output  1  high while a layer is in progress.
- done  output  1  one-cycle pulse when out1..out3 become valid.
- out1  output  64  share 1 of the result.
- out2  output  64  share 2 of the result.
- out3  output  64  share 3 of the result.

Behaviour:
- Function per nibble: XOR(out shares) = Sinv(XOR(in shares)), with Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for inputs 0..F.
- Core structure: input affine layer, then REG0, then quadratic stage F (3-share, uses r), then REG1, then middle affine layer, then quadratic stage G (3-share, no fresh randomness), then REG2, then output affine layer.
  - The affine layers are the inverses of the encryption-side decomposition layers, applied in reverse order.
  - Every nonlinear output is registered before any recombination.
  - No path combines more than its permitted shares.
  - The core latency is 3 register stages.
- Input capture: on the edge where start=1 and busy=0, in1..in3 are loaded into three 64-bit shift registers and busy goes high.
- Feed: on the next NIBBLES edges, nibble k (k=0 is bits [3:0], LSB first) enters REG0. A 5-bit counter tracks feed and drain.
- Randomness: r is sampled by REG1 on feed edges 2..17 after start. Its value outside busy is don't-care.
- Collection: the REG2 output nibble passes through the output affine layer. It is shifted into the result registers out1..out3 MSB-side in, so that after 16 writes nibble k sits at bits [4k+3:4k].
- Timing: start is high in cycle 0. busy is high in cycles 1..19. done is high in cycle 19 only. out1..out3 are stable from cycle 19 until the next accepted start.
- out1..out3 hold their values while busy. They are updated only by collection shifts.
- start while busy: ignored, with no effect on the counter or data.
- start in the same cycle as done: accepted; a new layer begins and busy stays high.
- Reset: all registers (shift registers, REG0..REG2, counter, out1..out3) are cleared to 0; busy=0, done=0. Reset mid-operation aborts the layer and no done pulse follows.

Optional Feature:
- Macro INV_SBOX_OUT_CLEAR_EN.
  - Defined: on an accepted start, out1..out3 are cleared to 0 in the same edge, so no share of the previous result coexists with new collection writes.
  - Undefined: out1..out3 keep the previous result until collection shifts overwrite it.

Test Plan:
- Reset, then in1=in2=in3=0 and start in cycle 0 -> busy cycles 1..19, done only in cycle 19; out1^out2^out3 = 0x5555555555555555.
- Unmasked 0x0123456789ABCDEF split with random in2,in3 and random r each cycle -> out1^out2^out3 = 0x5EF8C12DB463079A; repeat with 1000 random sharings, identical result each time.
- Round trip: random state X through the encryption-side masked S-box layer, then through this block -> unmasked result equals X.
- Pulse start again in cycles 5 and 12 -> no effect; done still only in cycle 19 with the correct result. Start in cycle 19 -> second layer done in cycle 38.
- Assert rst in cycle 10 -> busy=0 and all outputs 0 from cycle 11; no done pulse; a fresh start afterwards completes normally.
- With INV_SBOX_OUT_CLEAR_EN defined, start after a nonzero result -> out1..out3 = 0 in cycle 1. With the macro undefined -> the previous result is still present in cycle 1.
